// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on the decode port when empty.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // First fetch address after reset unless the top is parameterised otherwise.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Depth of the fetched-entry buffer; this release supports exactly 2.
  localparam int DEFAULT_FIFO_DEPTH = 2;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Value held in empty FIFO slots so the decode port shows pc=0 / NOP.
  localparam fetch_entry_t NOP_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Two-entry shift-style FIFO of fetched {pc, instr} entries.
// Slot 0 is always the head, so the head is a plain register with no
// read mux in front of the decode stage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   occupancy
);

  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop_ok;

  // A pop on an empty buffer is meaningless; drop it here so callers need not care.
  assign pop_ok = pop && (occ_q != 2'd0);

  // Next-state: flush wins, otherwise shift toward slot 0 on pop and fill the first free slot on push.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    if (flush) begin
      slot0_d = NOP_ENTRY;
      slot1_d = NOP_ENTRY;
      occ_d   = 2'd0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (occ_q == 2'd0) begin
            slot0_d = push_entry;
            occ_d   = 2'd1;
          end else if (occ_q == 2'd1) begin
            slot1_d = push_entry;
            occ_d   = 2'd2;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          slot1_d = NOP_ENTRY;
          occ_d   = occ_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count; the new entry lands behind any survivor.
          if (occ_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_entry;
          end else begin
            slot0_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and count registers, cleared asynchronously so reset empties the buffer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_q <= NOP_ENTRY;
      slot1_q <= NOP_ENTRY;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head      = slot0_q;
  assign occupancy = occ_q;

  // The issue credit check upstream must never let a push arrive with no room.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!reset)
      !(push && !flush && !pop_ok && (occ_q == DEPTH_L))
  );

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches to a one-cycle
// latency instruction memory, buffers returned words, and hands them to
// decode over a valid/ready port. Redirects flush everything in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misaligned_err
);

  localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         misaligned_q, misaligned_d;

  logic [1:0]   occupancy;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         pop;
  logic         push;
  logic         issue;
  logic [2:0]   credit_used;

  // Credit logic: a new fetch may only issue if its word is guaranteed a FIFO slot
  // one cycle later, counting buffered entries, the word in flight and this cycle's pop.
  always_comb begin
    pop         = id_valid && id_ready;
    push        = inflight_q && !redirect_valid;
    credit_used = {1'b0, occupancy} + {2'b00, inflight_q};
    issue       = !redirect_valid && (credit_used < (DEPTH_L + {2'b00, pop}));
    push_entry  = '{pc: inflight_pc_q, instr: imem_instr};
  end

  // Next fetch state: redirect overrides everything, otherwise advance on issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    misaligned_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      // Low address bits are dropped; the misalignment is reported, not trapped here.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
  end

  // Fetch PC, in-flight tracking and the misalignment pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      misaligned_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .occupancy  (occupancy)
  );

  assign imem_pc        = fetch_pc_q;
  assign id_valid       = (occupancy != 2'd0);
  assign id_pc          = head.pc;
  assign id_instr       = head.instr;
  assign misaligned_err = misaligned_q;

endmodule : fetch_unit
